// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative RV64M multiply/divide unit for the EX stage. It holds the pipeline
// with stall_out while an M-op is in flight and returns one registered result
// together with a single-cycle done_out pulse.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start_in     in   M-op present in EX (level, held until done_out)
//   flush_in     in   synchronous abort, wins over start_in
//   funct3_in    in   000 MUL 001 MULH 010 MULHSU 011 MULHU
//                     100 DIV 101 DIVU 110 REM 111 REMU
//   word_in      in   *W form (32-bit operation, sign-extended result)
//   op_a_in      in   rs1 value
//   op_b_in      in   rs2 value
//   stall_out    out  start_in & ~done_out
//   busy_out     out  unit not idle
//   done_out     out  one-cycle pulse, result_out valid
//   result_out   out  last completed result
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start_in; captures operands and decodes the op
// S_MUL  | one cycle: full-width product, half selected into res_q
// S_DIV  | one restoring quotient bit per cycle, 64 or 32 iterations
// S_DONE | publishes res_q to result_out and pulses done_out

module ex_muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_in,
    input  logic            flush_in,
    input  logic [2:0]      funct3_in,
    input  logic            word_in,
    input  logic [XLEN-1:0] op_a_in,
    input  logic [XLEN-1:0] op_b_in,
    output logic            stall_out,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int CW = $clog2(XLEN) + 1;

    state_t          state_q, state_d;
    logic [1:0]      f3_q, f3_d;
    logic            word_q, word_d;
    logic [XLEN-1:0] a_q, a_d;          // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0] b_q, b_d;          // multiplier, or divisor magnitude
    logic [XLEN-1:0] rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] res_q, res_d;      // staged result, published in S_DONE
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // capture-time decode
    logic            ext_signed, div_signed;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_val, div0_rem;
    logic            a_neg, b_neg, b_zero, ovf;

    // DIVU/REMU W forms zero-extend their operands; everything else sign-extends
    assign ext_signed = ~(funct3_in[2] & funct3_in[0]);
    assign div_signed = ~funct3_in[0];

    assign a_ext = word_in ? {{(XLEN-32){ext_signed & op_a_in[31]}}, op_a_in[31:0]} : op_a_in;
    assign b_ext = word_in ? {{(XLEN-32){ext_signed & op_b_in[31]}}, op_b_in[31:0]} : op_b_in;

    assign a_neg  = div_signed & a_ext[XLEN-1];
    assign b_neg  = div_signed & b_ext[XLEN-1];
    assign mag_a  = a_neg ? -a_ext : a_ext;
    assign mag_b  = b_neg ? -b_ext : b_ext;

    assign min_val  = word_in ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign b_zero   = (b_ext == '0);
    assign ovf      = div_signed & (a_ext == min_val) & (b_ext == '1);
    // remainder of a divide by zero is the dividend, always sign-extended for W
    assign div0_rem = word_in ? {{(XLEN-32){op_a_in[31]}}, op_a_in[31:0]} : op_a_in;

    // multiply: operands sign- or zero-extended to 2*XLEN so one unsigned
    // multiplier serves all signedness combinations
    logic              mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] mul_a_x, mul_b_x, prod;
    logic [XLEN-1:0]   mul_lo, mul_hi, mul_res;

    assign mul_a_signed = (f3_q != 2'b11);
    assign mul_b_signed = ~f3_q[1];
    assign mul_a_x = {{XLEN{mul_a_signed & a_q[XLEN-1]}}, a_q};
    assign mul_b_x = {{XLEN{mul_b_signed & b_q[XLEN-1]}}, b_q};
    assign prod    = mul_a_x * mul_b_x;
    assign mul_lo  = prod[XLEN-1:0];
    assign mul_hi  = prod[2*XLEN-1:XLEN];
    assign mul_res = (f3_q == 2'b00)
                   ? (word_q ? {{(XLEN-32){mul_lo[31]}}, mul_lo[31:0]} : mul_lo)
                   : mul_hi;

    // one restoring division step
    logic [XLEN:0]   rem_sh, diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_nxt, quo_nxt, q_fix, r_fix, div_pick, div_res;

    assign rem_sh   = {rem_q, a_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, b_q};
    assign q_bit    = ~diff[XLEN];
    assign rem_nxt  = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nxt  = {a_q[XLEN-2:0], q_bit};
    assign q_fix    = neg_quo_q ? -quo_nxt : quo_nxt;
    assign r_fix    = neg_rem_q ? -rem_nxt : rem_nxt;
    assign div_pick = f3_q[1] ? r_fix : q_fix;
    assign div_res  = word_q ? {{(XLEN-32){div_pick[31]}}, div_pick[31:0]} : div_pick;

    always_comb begin
        state_d   = state_q;
        f3_d      = f3_q;
        word_d    = word_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        result_d  = result_q;
        done_d    = 1'b0;

        if (flush_in) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // while done_q is high, start_in still belongs to the
                    // instruction that just completed
                    if (start_in && !done_q) begin
                        f3_d   = funct3_in[1:0];
                        word_d = word_in;
                        if (!funct3_in[2]) begin
                            a_d     = a_ext;
                            b_d     = b_ext;
                            state_d = S_MUL;
                        end else if (b_zero) begin
                            res_d   = funct3_in[1] ? div0_rem : '1;
                            state_d = S_DONE;
                        end else if (ovf) begin
                            res_d   = funct3_in[1] ? '0 : a_ext;
                            state_d = S_DONE;
                        end else begin
                            // W dividends are left-aligned so the loop runs 32 steps
                            a_d       = word_in ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                            b_d       = mag_b;
                            rem_d     = '0;
                            cnt_d     = word_in ? CW'(32) : CW'(XLEN);
                            neg_quo_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            state_d   = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    res_d   = mul_res;
                    state_d = S_DONE;
                end
                S_DIV: begin
                    a_d   = quo_nxt;
                    rem_d = rem_nxt;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        res_d   = div_res;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    done_d   = 1'b1;
                    result_d = res_q;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            f3_q      <= '0;
            word_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            f3_q      <= f3_d;
            word_q    <= word_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy_out   = busy_q;
    assign done_out   = done_q;
    assign result_out = result_q;
    assign stall_out  = start_in & ~done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit. Inputs change on the falling edge,
// outputs are sampled 1 ns after the rising edge.

module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset_n;
    logic        start_in;
    logic        flush_in;
    logic [2:0]  funct3_in;
    logic        word_in;
    logic [63:0] op_a_in;
    logic [63:0] op_b_in;
    logic        stall_out;
    logic        busy_out;
    logic        done_out;
    logic [63:0] result_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] last_res = 64'h0;

    ex_muldiv_unit #(.XLEN(64)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_in   (start_in),
        .flush_in   (flush_in),
        .funct3_in  (funct3_in),
        .word_in    (word_in),
        .op_a_in    (op_a_in),
        .op_b_in    (op_b_in),
        .stall_out  (stall_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .result_out (result_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // issue one op, wait for done, check result, latency and stall profile,
    // then hold start_in across the next edge to make sure it is not recaptured
    task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int lat);
        int k;
        int stall_cnt;
        @(negedge clk);
        funct3_in = f3;
        word_in   = w;
        op_a_in   = a;
        op_b_in   = b;
        start_in  = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        stall_cnt = 0;
        while (k < 200 && !done_out) begin
            if (stall_out) stall_cnt++;
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_done_seen"}, 64'(done_out), 64'd1);
        chk({tag, "_latency"}, 64'(k), 64'(lat));
        chk({tag, "_result"}, result_out, exp);
        chk({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
        chk({tag, "_stall_in_done"}, 64'(stall_out), 64'd0);
        last_res = exp;
        @(posedge clk);
        #1;
        start_in = 1'b0;
        chk({tag, "_no_recapture"}, 64'(busy_out), 64'd0);
        chk({tag, "_result_hold"}, result_out, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        reset_n   = 1'b0;
        start_in  = 1'b0;
        flush_in  = 1'b0;
        funct3_in = 3'b000;
        word_in   = 1'b0;
        op_a_in   = 64'h0;
        op_b_in   = 64'h0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   64'(busy_out), 64'd0);
        chk("rst_done",   64'(done_out), 64'd0);
        chk("rst_result", result_out, 64'h0);
        chk("rst_stall",  64'(stall_out), 64'd0);
        reset_n = 1'b1;

        // multiplies
        run_op("mul",    3'b000, 1'b0, 64'hFFFFFFFFFFFFFFFD, 64'd7,  64'hFFFFFFFFFFFFFFEB, 2);
        run_op("mulh",   3'b001, 1'b0, 64'h4000000000000000, 64'd4,  64'h0000000000000001, 2);
        run_op("mulhu",  3'b011, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 2);
        run_op("mulhsu", 3'b010, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd2,  64'hFFFFFFFFFFFFFFFF, 2);
        run_op("mulw",   3'b000, 1'b1, 64'h000000007FFFFFFF, 64'd2,  64'hFFFFFFFFFFFFFFFE, 2);

        // 64-bit divides
        run_op("div",      3'b100, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 64'hFFFFFFFFFFFFFFFA, 65);
        run_op("rem",      3'b110, 1'b0, 64'hFFFFFFFFFFFFFFEC, 64'd3, 64'hFFFFFFFFFFFFFFFE, 65);
        run_op("divu",     3'b101, 1'b0, 64'd20, 64'd3, 64'd6, 65);
        run_op("div_negb", 3'b100, 1'b0, 64'd20, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFA, 65);
        run_op("rem_negb", 3'b110, 1'b0, 64'd20, 64'hFFFFFFFFFFFFFFFD, 64'd2, 65);
        run_op("divu_big", 3'b101, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd10, 64'h1999999999999999, 65);
        run_op("remu_big", 3'b111, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd10, 64'd5, 65);

        // word divides
        run_op("divw",    3'b100, 1'b1, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 33);
        run_op("remw",    3'b110, 1'b1, 64'hDEADBEEFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33);
        run_op("divuw",   3'b101, 1'b1, 64'h00000000FFFFFFFF, 64'd2, 64'h000000007FFFFFFF, 33);
        run_op("remuw",   3'b111, 1'b1, 64'h0000000100000007, 64'h0000000100000003, 64'd1, 33);

        // special cases
        run_op("divw_ovf",  3'b100, 1'b1, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 1);
        run_op("div_ovf",   3'b100, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 1);
        run_op("rem_ovf",   3'b110, 1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1);
        run_op("divu_zero", 3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1);
        run_op("rem_zero",  3'b110, 1'b0, 64'hFFFFFFFFFFFFFFFB, 64'd0, 64'hFFFFFFFFFFFFFFFB, 1);
        run_op("remuw_zero", 3'b111, 1'b1, 64'h0000000080000000, 64'h0000000100000000, 64'hFFFFFFFF80000000, 1);

        // flush mid-divide
        @(negedge clk);
        funct3_in = 3'b100;
        word_in   = 1'b0;
        op_a_in   = 64'd100;
        op_b_in   = 64'd7;
        start_in  = 1'b1;
        @(posedge clk);
        #1;
        repeat (9) @(posedge clk);
        #1;
        flush_in = 1'b1;
        start_in = 1'b0;
        @(posedge clk);
        #1;
        chk("flush_busy",   64'(busy_out), 64'd0);
        chk("flush_done",   64'(done_out), 64'd0);
        chk("flush_result", result_out, last_res);
        flush_in = 1'b0;
        seen_done = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done_out) seen_done = 1'b1;
        end
        chk("flush_no_done", 64'(seen_done), 64'd0);
        run_op("mul_after_flush", 3'b000, 1'b0, 64'd9, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF7, 2);

        // asynchronous reset mid-divide
        @(negedge clk);
        funct3_in = 3'b100;
        word_in   = 1'b0;
        op_a_in   = 64'd1000;
        op_b_in   = 64'd7;
        start_in  = 1'b1;
        @(posedge clk);
        #1;
        repeat (20) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy",   64'(busy_out), 64'd0);
        chk("arst_done",   64'(done_out), 64'd0);
        chk("arst_result", result_out, 64'h0);
        start_in = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_op("mul_after_reset", 3'b000, 1'b0, 64'd6, 64'd7, 64'd42, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
